// File: rtl/layer1_fmap_buffer_if.sv
// Port bundle for layer1_fmap_buffer: upstream sample capture, window handshake and status.
interface layer1_fmap_buffer_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned NCH = 4,
    parameter int unsigned WIN = 5,
    parameter int unsigned AW  = 9
);
    logic                  start;
    logic                  in_valid;
    logic [DW-1:0]         in_ch0;
    logic [DW-1:0]         in_ch1;
    logic [DW-1:0]         in_ch2;
    logic [DW-1:0]         in_ch3;
    logic                  in_done;
    logic                  win_valid;
    logic                  win_ack;
    logic [NCH*WIN*DW-1:0] win_data;
    logic [AW-1:0]         win_idx;
    logic [AW-1:0]         fill_cnt;
    logic                  busy;
    logic                  layer_done;
    logic                  ovf_err;

    modport master (
        output start, in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_done, win_ack,
        input  win_valid, win_data, win_idx, fill_cnt, busy, layer_done, ovf_err
    );

    modport slave (
        input  start, in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_done, win_ack,
        output win_valid, win_data, win_idx, fill_cnt, busy, layer_done, ovf_err
    );
endinterface

// File: rtl/layer1_fmap_buffer.sv
// Layer-1 feature-map buffer: stores pooled 4-channel samples, replays WIN-tap sliding windows.
// Optional macro ZERO_PAD_EN selects 'same' zero padding of (WIN-1)/2 taps at both frame ends.
module layer1_fmap_buffer #(
    parameter int unsigned DW     = 8,
    parameter int unsigned DEPTH  = 500,
    parameter int unsigned WIN    = 5,
    parameter int unsigned STRIDE = 1
) (
    input  logic                clk,
    input  logic                rst,
    layer1_fmap_buffer_if.slave bus
);
    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned KW  = $clog2(WIN + 1);
    localparam int unsigned RW  = NCH * DW;
    localparam int unsigned WW  = WIN * DW;

    typedef enum logic [2:0] {IDLE, FILL, LOAD, HOLD, FIN} state_t;

    state_t            state;
    logic [AW-1:0]     fill_cnt;
    logic [AW-1:0]     base;
    logic [AW-1:0]     win_idx;
    logic [KW-1:0]     ld_cnt;
    logic              win_valid;
    logic              busy;
    logic              layer_done;
    logic              ovf_err;
    logic [NCH*WW-1:0] win_q;
    logic [RW-1:0]     mem [DEPTH];
    logic [RW-1:0]     rd_data;
    logic [RW-1:0]     tap_in_c;

    logic              wr_en_c;
    logic              rd_en_c;
    logic              has_win_c;
    logic              more_c;
    logic [AW-1:0]     cnt_nx_c;
    logic [AW-1:0]     nwin_c;
    logic [AW-1:0]     rd_addr_c;
    logic [PW-1:0]     base_nx_c;

    assign wr_en_c   = (state == FILL) && bus.in_valid && (fill_cnt < AW'(DEPTH));
    assign cnt_nx_c  = fill_cnt + AW'(wr_en_c);
    assign base_nx_c = PW'(base) + PW'(STRIDE);
    assign more_c    = base_nx_c < PW'(nwin_c);

`ifdef ZERO_PAD_EN
    localparam int unsigned PAD = (WIN - 1) / 2;
    logic [PW-1:0] pos_c;
    logic [PW-1:0] rel_c;
    logic          rd_oob_c;
    logic          rd_zero;

    // Tap position relative to the window base; taps outside 0..fill_cnt-1 read as zero.
    assign pos_c     = PW'(base) + PW'(ld_cnt);
    assign rel_c     = pos_c - PW'(PAD);
    assign rd_oob_c  = (pos_c < PW'(PAD)) || (rel_c >= PW'(fill_cnt));
    assign rd_addr_c = rel_c[AW-1:0];
    assign rd_en_c   = (state == LOAD) && (ld_cnt < KW'(WIN)) && !rd_oob_c;
    assign nwin_c    = fill_cnt;
    assign has_win_c = cnt_nx_c != '0;
    assign tap_in_c  = rd_zero ? '0 : rd_data;

    always_ff @(posedge clk) begin
        rd_zero <= rd_oob_c;
    end
`else
    assign rd_addr_c = base + AW'(ld_cnt);
    assign rd_en_c   = (state == LOAD) && (ld_cnt < KW'(WIN));
    assign nwin_c    = (fill_cnt >= AW'(WIN)) ? fill_cnt - AW'(WIN - 1) : '0;
    assign has_win_c = cnt_nx_c >= AW'(WIN);
    assign tap_in_c  = rd_data;
`endif

    // Sample RAM: all four channels share one word; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[fill_cnt] <= {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0};
        if (rd_en_c) rd_data <= mem[rd_addr_c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            base       <= '0;
            ld_cnt     <= '0;
            win_idx    <= '0;
            win_q      <= '0;
            win_valid  <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fill_cnt <= '0;
                        ovf_err  <= bus.in_valid;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end else if (bus.in_valid) begin
                        ovf_err <= 1'b1;
                    end
                end
                FILL: begin
                    fill_cnt <= cnt_nx_c;
                    if (bus.in_valid && !wr_en_c) ovf_err <= 1'b1;
                    // Same-cycle in_done still keeps the final sample.
                    if (bus.in_done || (cnt_nx_c == AW'(DEPTH))) begin
                        base   <= '0;
                        ld_cnt <= '0;
                        if (has_win_c) begin
                            state <= LOAD;
                        end else begin
                            state      <= FIN;
                            layer_done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid) ovf_err <= 1'b1;
                    // Newest tap enters the top slot; tap 0 ends up holding the oldest sample.
                    if (ld_cnt != '0) begin
                        for (int c = 0; c < NCH; c++) begin
                            win_q[c*WW +: WW] <= {tap_in_c[c*DW +: DW], win_q[c*WW + DW +: WW - DW]};
                        end
                    end
                    if (ld_cnt == KW'(WIN)) begin
                        win_valid <= 1'b1;
                        win_idx   <= base;
                        state     <= HOLD;
                    end else begin
                        ld_cnt <= ld_cnt + KW'(1);
                    end
                end
                HOLD: begin
                    if (bus.in_valid) ovf_err <= 1'b1;
                    if (bus.win_ack) begin
                        win_valid <= 1'b0;
                        base      <= base_nx_c[AW-1:0];
                        ld_cnt    <= '0;
                        if (more_c) begin
                            state <= LOAD;
                        end else begin
                            state      <= FIN;
                            layer_done <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    if (bus.in_valid) ovf_err <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.win_valid  = win_valid;
    assign bus.win_data   = win_q;
    assign bus.win_idx    = win_idx;
    assign bus.fill_cnt   = fill_cnt;
    assign bus.busy       = busy;
    assign bus.layer_done = layer_done;
    assign bus.ovf_err    = ovf_err;
endmodule

// File: tb/tb_layer1_fmap_buffer.sv
// Scoreboard bench for layer1_fmap_buffer: expected windows queued at stimulus, checked by a monitor.
module tb_layer1_fmap_buffer;
    localparam int WIN   = 5;
    localparam int DEPTH = 500;
    localparam int WDW   = 4 * WIN * 8;

    typedef struct {
        int             idx;
        logic [WDW-1:0] data;
    } win_t;

    logic clk;
    logic rst;

    layer1_fmap_buffer_if #(.DW(8), .NCH(4), .WIN(WIN), .AW(9)) bus ();

    layer1_fmap_buffer #(.DW(8), .DEPTH(DEPTH), .WIN(WIN), .STRIDE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    int         ack_en = 1;
    int         hold_cycles = 0;
    int         stray_req = 0;
    win_t       exp_q[$];
    logic [7:0] smp [4][DEPTH+4];

    // Monitor: pops one expected window per rising win_valid, then checks it stays stable.
    initial begin : monitor
        logic           vprev;
        int             hidx;
        logic [WDW-1:0] hdata;
        win_t           e;
        vprev = 1'b0;
        hidx  = 0;
        hdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                vprev = 1'b0;
            end else begin
                if (bus.layer_done) done_seen++;
                if (bus.win_valid && !vprev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL win_extra actual idx=%0d required no window", bus.win_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(bus.win_idx) != e.idx || bus.win_data !== e.data) begin
                            errors++;
                            $display("FAIL win_data actual idx=%0d data=%h required idx=%0d data=%h",
                                     bus.win_idx, bus.win_data, e.idx, e.data);
                        end
                    end
                    hidx  = int'(bus.win_idx);
                    hdata = bus.win_data;
                end else if (bus.win_valid) begin
                    checks++;
                    if (int'(bus.win_idx) != hidx || bus.win_data !== hdata) begin
                        errors++;
                        $display("FAIL win_stable actual idx=%0d data=%h required idx=%0d data=%h",
                                 bus.win_idx, bus.win_data, hidx, hdata);
                    end
                end
                vprev = bus.win_valid;
            end
        end
    end

    // Consumer: acks each window after hold_cycles; optionally adds a stray ack while win_valid=0.
    initial begin : consumer
        int stray_done;
        stray_done  = 0;
        bus.win_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ack_en != 0 && bus.win_valid) begin
                repeat (hold_cycles) @(negedge clk);
                bus.win_ack = 1'b1;
                @(negedge clk);
                bus.win_ack = 1'b0;
                if (stray_req != stray_done) begin
                    @(negedge clk);
                    bus.win_ack = 1'b1;
                    @(negedge clk);
                    bus.win_ack = 1'b0;
                    stray_done++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int n, input bit with_done);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_ch0   = smp[0][i];
            bus.in_ch1   = smp[1][i];
            bus.in_ch2   = smp[2][i];
            bus.in_ch3   = smp[3][i];
            bus.in_done  = with_done && (i == n - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_done  = 1'b0;
        if (n == 0 && with_done) begin
            bus.in_done = 1'b1;
            tick();
            bus.in_done = 1'b0;
        end
    endtask

    // Reference windows for n stored samples; out-of-range taps are zero in padded builds.
    task automatic push_windows(input int n);
        int   nw;
        int   pad;
        int   s;
        win_t e;
`ifdef ZERO_PAD_EN
        pad = (WIN - 1) / 2;
        nw  = n;
`else
        pad = 0;
        nw  = (n >= WIN) ? n - WIN + 1 : 0;
`endif
        for (int b = 0; b < nw; b++) begin
            e.idx  = b;
            e.data = '0;
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < WIN; k++) begin
                    s = b + k - pad;
                    if (s >= 0 && s < n) e.data[(c*WIN+k)*8 +: 8] = smp[c][s];
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while (bus.busy && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL %s_timeout actual busy=1 required busy=0 within %0d cycles", name, budget);
        end
    endtask

    task automatic frame_end(input string name, input int fill, input int ovf, input int d0);
        chk({name, "_fill_cnt"}, int'(bus.fill_cnt), fill);
        chk({name, "_ovf_err"}, int'(bus.ovf_err), ovf);
        chk({name, "_done_pulses"}, done_seen - d0, 1);
        chk({name, "_windows_left"}, exp_q.size(), 0);
    endtask

    initial begin : stim
        int d0;
        int t;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_done  = 1'b0;
        bus.in_ch0   = '0;
        bus.in_ch1   = '0;
        bus.in_ch2   = '0;
        bus.in_ch3   = '0;
        tick();
        tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_win_valid", int'(bus.win_valid), 0);
        chk("rst_layer_done", int'(bus.layer_done), 0);
        chk("rst_ovf_err", int'(bus.ovf_err), 0);
        chk("rst_fill_cnt", int'(bus.fill_cnt), 0);
        chk("rst_win_idx", int'(bus.win_idx), 0);
        chk("rst_win_data_zero", int'(bus.win_data == '0), 1);
        rst = 1'b0;
        tick();

        // Reset in HOLD with ovf_err set, then in_valid in IDLE without start
        for (int i = 0; i < 8; i++) begin
            smp[0][i] = 8'(i);
            smp[1][i] = 8'(-(i + 1));
            smp[2][i] = 8'(-(i + 1));
            smp[3][i] = 8'(-(i + 1));
        end
        ack_en = 0;
        push_windows(8);
        start_frame();
        send(8, 1'b1);
        t = 0;
        while (!bus.win_valid && t < 50) begin
            tick();
            t++;
        end
        chk("t1_reach_hold", int'(bus.win_valid), 1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t1_ovf_in_hold", int'(bus.ovf_err), 1);
        #2 rst = 1'b1;
        tick();
        chk("t1_rst_busy", int'(bus.busy), 0);
        chk("t1_rst_win_valid", int'(bus.win_valid), 0);
        chk("t1_rst_ovf_err", int'(bus.ovf_err), 0);
        rst = 1'b0;
        exp_q.delete();
        ack_en = 1;
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t1_idle_busy", int'(bus.busy), 0);
        chk("t1_idle_fill_cnt", int'(bus.fill_cnt), 0);
        chk("t1_idle_ovf_err", int'(bus.ovf_err), 1);

        // Eight samples, in_done on the last beat
        d0 = done_seen;
        push_windows(8);
        start_frame();
        chk("t2_start_clears_ovf", int'(bus.ovf_err), 0);
        chk("t2_busy", int'(bus.busy), 1);
        send(8, 1'b1);
        wait_idle("t2", 300);
        frame_end("t2", 8, 0, d0);

        // Ack held 50 cycles per window plus a stray ack while win_valid=0
        d0 = done_seen;
        hold_cycles = 50;
        stray_req   = 1;
        push_windows(6);
        start_frame();
        send(6, 1'b1);
        wait_idle("t6", 1000);
        frame_end("t6", 6, 0, d0);
        hold_cycles = 0;

        // Two samples only: no full window in valid mode
        d0 = done_seen;
        push_windows(2);
        start_frame();
        send(2, 1'b1);
`ifndef ZERO_PAD_EN
        chk("t4_done_after_fill", int'(bus.layer_done), 1);
        chk("t4_busy_in_fin", int'(bus.busy), 1);
        tick();
        chk("t4_done_one_cycle", int'(bus.layer_done), 0);
        chk("t4_busy_fall", int'(bus.busy), 0);
`endif
        wait_idle("t4", 200);
        frame_end("t4", 2, 0, d0);

        // Exactly WIN samples
        d0 = done_seen;
        push_windows(WIN);
        start_frame();
        send(WIN, 1'b1);
        wait_idle("win_exact", 200);
        frame_end("win_exact", WIN, 0, d0);

        // Empty frame
        d0 = done_seen;
        start_frame();
        send(0, 1'b1);
        wait_idle("empty", 20);
        frame_end("empty", 0, 0, d0);

        // 502 beats with no in_done: buffer fills at DEPTH, last two beats dropped
        for (int i = 0; i < DEPTH + 2; i++) begin
            smp[0][i] = 8'(i);
            smp[1][i] = 8'(i * 7 + 3);
            smp[2][i] = 8'(255 - i);
            smp[3][i] = 8'(i ^ 90);
        end
        d0 = done_seen;
        push_windows(DEPTH);
        start_frame();
        send(DEPTH + 2, 1'b0);
        wait_idle("t3", 20000);
        frame_end("t3", DEPTH, 1, d0);

`ifdef ZERO_PAD_EN
        // Padded windows over three samples
        smp[0][0] = 8'd10;
        smp[0][1] = 8'd20;
        smp[0][2] = 8'd30;
        for (int i = 0; i < 3; i++) begin
            smp[1][i] = 8'(-(i + 1));
            smp[2][i] = 8'(i + 100);
            smp[3][i] = 8'(i + 200);
        end
        d0 = done_seen;
        push_windows(3);
        start_frame();
        send(3, 1'b1);
        wait_idle("t5", 300);
        frame_end("t5", 3, 0, d0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
